// File: rtl/btb_fetch_pc.sv
// Fetch-stage PC register with a direct-mapped branch target buffer and a pending-redirect latch.
// Optional saturating lookup/hit counters are built when BTB_PERF_COUNTERS_EN is defined.
module btb_fetch_pc #(
  parameter int          idx_bits = 4,
  parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        predict_dir,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic [6:0]  ex_mem_opcode,
  input  logic [31:0] ex_mem_pc,
  input  logic [31:0] ex_mem_target,
  input  logic        ex_mem_br_en,
  output logic [31:0] pc,
  output logic        btb_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic [31:0] perf_lookups,
  output logic [31:0] perf_hits
);

  localparam int          entries = 1 << idx_bits;
  localparam int          tag_w   = 30 - idx_bits;
  localparam logic [6:0]  op_br   = 7'b110_0011;
  localparam logic [6:0]  op_jal  = 7'b110_1111;
  localparam logic [6:0]  op_jalr = 7'b110_0111;

  function automatic logic is_cti(input logic [6:0] opcode);
    logic hit;
    case (opcode)
      op_br, op_jal, op_jalr: hit = 1'b1;
      default:                hit = 1'b0;
    endcase
    return hit;
  endfunction

  logic [31:0]         pc_r;
  logic                pend_valid_r;
  logic [31:0]         pend_pc_r;
  logic [entries-1:0]  valid_r;
  logic [tag_w-1:0]    tag_r    [entries];
  logic [31:0]         target_r [entries];

  logic [idx_bits-1:0] rd_idx_s;
  logic [tag_w-1:0]    rd_tag_s;
  logic [idx_bits-1:0] wr_idx_s;
  logic                btb_hit_s;
  logic                pred_taken_s;
  logic [31:0]         pred_target_s;
  logic [31:0]         next_pc_s;
  logic                btb_we_s;
  logic                unused_s;

  assign rd_idx_s = pc_r[idx_bits+1:2];
  assign rd_tag_s = pc_r[31:idx_bits+2];
  assign wr_idx_s = ex_mem_pc[idx_bits+1:2];
  assign unused_s = ^ex_mem_pc[1:0];

  // Combinational lookup, next-PC selection and BTB write enable
  always_comb begin
    btb_hit_s     = 1'b0;
    pred_taken_s  = 1'b0;
    pred_target_s = pc_r + 32'd4;
    next_pc_s     = pc_r;
    btb_we_s      = 1'b0;

    btb_hit_s    = valid_r[rd_idx_s] && (tag_r[rd_idx_s] == rd_tag_s);
    pred_taken_s = btb_hit_s && predict_dir;
    if (pred_taken_s) begin
      pred_target_s = target_r[rd_idx_s];
    end else begin
      pred_target_s = pc_r + 32'd4;
    end

    if (pend_valid_r) begin
      next_pc_s = pend_pc_r;
    end else if (redirect) begin
      next_pc_s = redirect_pc;
    end else begin
      next_pc_s = pred_target_s;
    end

    if (!stall && ex_mem_br_en && is_cti(ex_mem_opcode)) begin
      btb_we_s = 1'b1;
    end else begin
      btb_we_s = 1'b0;
    end
  end

  // PC register and pending redirect; a stalled redirect is parked until the stall lifts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r         <= RESET_PC;
      pend_valid_r <= 1'b0;
      pend_pc_r    <= 32'h0000_0000;
    end else if (!stall) begin
      pc_r         <= next_pc_s;
      pend_valid_r <= 1'b0;
    end else if (redirect) begin
      pend_valid_r <= 1'b1;
      pend_pc_r    <= redirect_pc;
    end
  end

  // Valid bits are the only BTB state that needs reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= '0;
    end else if (btb_we_s) begin
      valid_r[wr_idx_s] <= 1'b1;
    end
  end

  // Tag and target storage
  always_ff @(posedge clk) begin
    if (btb_we_s) begin
      tag_r[wr_idx_s]    <= ex_mem_pc[31:idx_bits+2];
      target_r[wr_idx_s] <= ex_mem_target;
    end
  end

  assign pc          = pc_r;
  assign btb_hit     = btb_hit_s;
  assign pred_taken  = pred_taken_s;
  assign pred_target = pred_target_s;

`ifdef BTB_PERF_COUNTERS_EN
  logic [31:0] lookups_r;
  logic [31:0] hits_r;

  // Saturating counters for unstalled fetches and predicted-taken fetches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lookups_r <= 32'h0000_0000;
      hits_r    <= 32'h0000_0000;
    end else if (!stall) begin
      if (lookups_r != 32'hFFFF_FFFF) begin
        lookups_r <= lookups_r + 32'd1;
      end
      if (pred_taken_s && (hits_r != 32'hFFFF_FFFF)) begin
        hits_r <= hits_r + 32'd1;
      end
    end
  end

  assign perf_lookups = lookups_r;
  assign perf_hits    = hits_r;
`else
  assign perf_lookups = 32'h0000_0000;
  assign perf_hits    = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_btb_fetch_pc.sv
// Directed self-checking bench for btb_fetch_pc with hand-computed expectations.
module tb_btb_fetch_pc;

  localparam logic [6:0] OP_BR   = 7'b110_0011;
  localparam logic [6:0] OP_JAL  = 7'b110_1111;
  localparam logic [6:0] OP_JALR = 7'b110_0111;
  localparam logic [6:0] OP_ALU  = 7'b011_0011;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        predict_dir;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [6:0]  ex_mem_opcode;
  logic [31:0] ex_mem_pc;
  logic [31:0] ex_mem_target;
  logic        ex_mem_br_en;
  logic [31:0] pc;
  logic        btb_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [31:0] perf_lookups;
  logic [31:0] perf_hits;

  int n_checks;
  int n_fail;

  btb_fetch_pc dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .predict_dir  (predict_dir),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .ex_mem_opcode(ex_mem_opcode),
    .ex_mem_pc    (ex_mem_pc),
    .ex_mem_target(ex_mem_target),
    .ex_mem_br_en (ex_mem_br_en),
    .pc           (pc),
    .btb_hit      (btb_hit),
    .pred_taken   (pred_taken),
    .pred_target  (pred_target),
    .perf_lookups (perf_lookups),
    .perf_hits    (perf_hits)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // advance one posedge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall         = 1'b0;
    redirect      = 1'b0;
    redirect_pc   = 32'h0000_0000;
    ex_mem_opcode = OP_ALU;
    ex_mem_pc     = 32'h0000_0000;
    ex_mem_target = 32'h0000_0000;
    ex_mem_br_en  = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    predict_dir = 1'b0;
    idle_inputs();
    rst = 1'b1;
    #2;
    check_val("rst_pc", pc, 32'h4000_0000);
    check_val("rst_hit", {31'd0, btb_hit}, 32'd0);
    check_val("rst_ptk", {31'd0, pred_taken}, 32'd0);
    check_val("rst_ptgt", pred_target, 32'h4000_0004);
    check_val("rst_lk", perf_lookups, 32'd0);
    check_val("rst_ht", perf_hits, 32'd0);
    rst = 1'b0;
    #1;
    check_val("seq0", pc, 32'h4000_0000);
    tick();
    check_val("seq1", pc, 32'h4000_0004);
    check_val("seq1_hit", {31'd0, btb_hit}, 32'd0);
    tick();
    check_val("seq2", pc, 32'h4000_0008);
    check_val("seq2_hit", {31'd0, btb_hit}, 32'd0);

    // taken branch at 0010 -> 0100 written while redirecting fetch to 0010
    ex_mem_opcode = OP_BR; ex_mem_pc = 32'h4000_0010; ex_mem_target = 32'h4000_0100; ex_mem_br_en = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h4000_0010;
    tick();
    idle_inputs();
    predict_dir = 1'b0;
    #1;
    check_val("redir_pc", pc, 32'h4000_0010);
    check_val("nt_hit", {31'd0, btb_hit}, 32'd1);
    check_val("nt_ptk", {31'd0, pred_taken}, 32'd0);
    check_val("nt_ptgt", pred_target, 32'h4000_0014);
    predict_dir = 1'b1;
    #1;
    check_val("tk_hit", {31'd0, btb_hit}, 32'd1);
    check_val("tk_ptk", {31'd0, pred_taken}, 32'd1);
    check_val("tk_ptgt", pred_target, 32'h4000_0100);
    tick();
    check_val("tk_next", pc, 32'h4000_0100);
    check_val("idx0_miss", {31'd0, btb_hit}, 32'd0);

    // not-taken resolution must not disturb the entry
    ex_mem_opcode = OP_BR; ex_mem_pc = 32'h4000_0010; ex_mem_target = 32'h4000_0AAA; ex_mem_br_en = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h4000_0010;
    tick();
    idle_inputs();
    #1;
    check_val("ntres_hit", {31'd0, btb_hit}, 32'd1);
    check_val("ntres_tgt", pred_target, 32'h4000_0100);

    // non-CTI opcode with br_en must not write; 0050 aliases index of 0010
    ex_mem_opcode = OP_ALU; ex_mem_pc = 32'h4000_0050; ex_mem_target = 32'h4000_0500; ex_mem_br_en = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h4000_0050;
    tick();
    check_val("alias_pc", pc, 32'h4000_0050);
    check_val("alias_miss", {31'd0, btb_hit}, 32'd0);

    // write and lookup to the same index in one cycle: old contents seen first
    ex_mem_opcode = OP_JAL; ex_mem_pc = 32'h4000_0050; ex_mem_target = 32'h4000_0300; ex_mem_br_en = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h4000_0050;
    #1;
    check_val("bypass_old", {31'd0, btb_hit}, 32'd0);
    tick();
    idle_inputs();
    #1;
    check_val("bypass_new", {31'd0, btb_hit}, 32'd1);
    check_val("bypass_tgt", pred_target, 32'h4000_0300);

    // stalled redirect, overwritten by a newer one; stalled jalr must not write
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h4000_0180;
    ex_mem_opcode = OP_JALR; ex_mem_pc = 32'h4000_0080; ex_mem_target = 32'h4000_0800; ex_mem_br_en = 1'b1;
    tick();
    check_val("stall1_pc", pc, 32'h4000_0050);
    redirect_pc = 32'h4000_0200;
    tick();
    check_val("stall2_pc", pc, 32'h4000_0050);
    idle_inputs();
    redirect = 1'b1; redirect_pc = 32'h4000_0080;
    tick();
    check_val("pend_apply", pc, 32'h4000_0200);
    tick();
    check_val("after_pend", pc, 32'h4000_0080);
    check_val("stall_nowr", {31'd0, btb_hit}, 32'd0);

    // reset mid-pending discards the pending redirect and clears the BTB
    idle_inputs();
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h4000_0600;
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_val("arst_pc", pc, 32'h4000_0000);
    check_val("arst_ptgt", pred_target, 32'h4000_0004);
    idle_inputs();
    #1;
    rst = 1'b0;
    tick();
    check_val("arst_nopend", pc, 32'h4000_0004);
    redirect = 1'b1; redirect_pc = 32'h4000_0050;
    tick();
    idle_inputs();
    #1;
    check_val("arst_clrv", {31'd0, btb_hit}, 32'd0);

    // perf: 10 unstalled edges, 3 of them predicted-taken, then one stalled edge
    rst = 1'b1;
    #1;
    rst = 1'b0;
    predict_dir = 1'b1;
    ex_mem_opcode = OP_BR; ex_mem_pc = 32'h4000_0008; ex_mem_target = 32'h4000_0008; ex_mem_br_en = 1'b1;
    tick();
    idle_inputs();
    tick();
    check_val("loop_pc", pc, 32'h4000_0008);
    for (int i = 0; i < 3; i++) begin
      check_val("loop_ptk", {31'd0, pred_taken}, 32'd1);
      tick();
    end
    predict_dir = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
    end
    check_val("perf_pc", pc, 32'h4000_001C);
    stall = 1'b1;
    tick();
    stall = 1'b0;
`ifdef BTB_PERF_COUNTERS_EN
    check_val("perf_lk", perf_lookups, 32'd10);
    check_val("perf_ht", perf_hits, 32'd3);
`else
    check_val("perf_lk", perf_lookups, 32'd0);
    check_val("perf_ht", perf_hits, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/btb_fetch_pc.md
BTB_FETCH_PC -- requirements
Module: btb_fetch_pc

Interface
REQ-001 SHALL have parameter idx_bits, default 4: BTB index width; 2^idx_bits entries.
REQ-002 SHALL have parameter RESET_PC, default 32'h4000_0000: PC value loaded on reset.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  pipeline stall; freezes the PC register and BTB writes.
REQ-006 SHALL have port predict_dir  input  1  direction from the local predictor for the current pc.
REQ-007 SHALL have port redirect  input  1  mispredict or flush from EX/MEM.
REQ-008 SHALL have port redirect_pc  input  32  correct next PC accompanying redirect.
REQ-009 SHALL have port ex_mem_opcode  input  7  opcode of the instruction resolving in EX/MEM.
REQ-010 SHALL have port ex_mem_pc  input  32  PC of the resolving instruction.
REQ-011 SHALL have port ex_mem_target  input  32  computed target of the resolving instruction.
REQ-012 SHALL have port ex_mem_br_en  input  1  resolved taken flag.
REQ-013 SHALL have port pc  output  32  current fetch PC, fed to I-cache and local predictor.
REQ-014 SHALL have port btb_hit  output  1  valid tag match for pc.
REQ-015 SHALL have port pred_taken  output  1  btb_hit AND predict_dir; carried down the pipe for mispredict checks.
REQ-016 SHALL have port pred_target  output  32  next PC this block selected (pc+4 or BTB target).
REQ-017 SHALL have port perf_lookups  output  32  fetch-lookup counter (see Configuration).
REQ-018 SHALL have port perf_hits  output  32  predicted-taken counter (see Configuration).

Function
REQ-019 Each BTB entry SHALL hold a valid bit, tag = pc[31:idx_bits+2], and a 32-bit target; index = pc[idx_bits+1:2].
REQ-020 Lookup SHALL be combinational on pc; btb_hit = valid AND tag equal.
REQ-021 pred_target SHALL be the BTB target when pred_taken=1, else pc+4 (mod 2^32, wrapping).
REQ-022 Next-PC priority SHALL be: pending redirect, then redirect, then pred_target.
REQ-023 When stall=0, the PC register SHALL load the selected next PC at posedge.
REQ-024 When stall=1 and redirect=1, redirect_pc SHALL be captured in a pending register; the PC SHALL hold.
REQ-025 The pending redirect SHALL be applied on the first posedge with stall=0 and then cleared.
REQ-026 A newer redirect arriving while a redirect is pending SHALL overwrite the pending target.
REQ-027 A BTB write SHALL occur when stall=0, ex_mem_br_en=1, and ex_mem_opcode is op_br, op_jal or op_jalr; the written entry SHALL be set valid with tag and target from ex_mem_pc and ex_mem_target.
REQ-028 A not-taken resolution SHALL NOT modify or invalidate any entry.
REQ-029 A write and a lookup to the same index in one cycle SHALL return the pre-write contents; the new contents become visible the next cycle.
REQ-030 No BTB write or PC change SHALL occur while stall=1, except capture of the pending redirect.

Reset
REQ-031 Assertion of rst SHALL immediately, without waiting for a clock edge, set pc to RESET_PC, clear all valid bits, clear the pending flag, and zero the perf counters.
REQ-032 Following rst assertion, btb_hit and pred_taken SHALL be 0 and pred_target SHALL be RESET_PC+4.
REQ-033 A reset asserted mid-stall or mid-pending SHALL discard the pending redirect.

Configuration
REQ-034 With macro BTB_PERF_COUNTERS_EN defined:
  - perf_lookups SHALL increment on every posedge with stall=0.
  - perf_hits SHALL increment on every posedge with stall=0 and pred_taken=1.
  - Both counters SHALL saturate at 32'hFFFF_FFFF.
REQ-035 Without BTB_PERF_COUNTERS_EN, both counters SHALL be tied to 0 and no counter flops SHALL be built.

Verification
REQ-036 Reset, then 3 unstalled cycles -> pc sequence 4000_0000, 4000_0004, 4000_0008; btb_hit=0.
REQ-037 Taken op_br at ex_mem_pc 4000_0010, target 4000_0100, then fetch 4000_0010 with predict_dir=1 -> btb_hit=1, next pc 4000_0100.
REQ-038 Same entry, predict_dir=0 -> btb_hit=1, pred_taken=0, next pc 4000_0014.
REQ-039 Entry at 4000_0010 valid, fetch 4000_0050 (same index, different tag) -> btb_hit=0.
REQ-040 Redirect to 4000_0200 with stall=1 for 2 cycles, then stall=0 -> pc holds, then becomes 4000_0200.
REQ-041 Macro defined, 10 unstalled cycles with 3 predicted-taken -> perf_lookups=10, perf_hits=3; macro undefined -> both 0.
